uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one UART transmitter (8N1 byte TX: i_TX_DV/i_TX_Byte in, o_TX_Active/o_TX_Done out)
//  between NUM_CH packet requesters. Round-robin grant held for a whole packet so packets never
//  interleave; optional header byte tags each packet with its channel id. Sits between
//  debug/status sources and the TX; owns all sequencing of the TX's DV/Done handshake.
// PARAMETERS
//  NUM_CH       4      number of requester channels (2..16)
//  HEADER_EN    1      1: prepend header byte {HEADER_TAG, chan id} to each packet; 0: none
//  HEADER_TAG   4'hA   upper nibble of header byte
//  GAP_TIMEOUT  1024   max idle cycles inside a packet before abort; 0 disables timeout
// PORTS
//  i_Clock        in   1          system clock, all logic rising-edge
//  i_Rst          in   1          synchronous reset, active-high
//  i_Req_Valid    in   NUM_CH     per-channel byte valid
//  i_Req_Byte     in   8*NUM_CH   per-channel byte; ch k at [8k+7:8k]
//  i_Req_Last     in   NUM_CH     qualifies byte as last of packet
//  o_Req_Ready    out  NUM_CH     per-channel ready; byte taken when valid&ready
//  o_TX_DV        out  1          launch request to transmitter
//  o_TX_Byte      out  8          byte to transmitter, stable while o_TX_DV high
//  i_TX_Active    in   1          transmitter busy
//  i_TX_Done      in   1          transmitter one-cycle completion pulse
//  o_Grant        out  NUM_CH     one-hot current owner; 0 when idle
//  o_Busy         out  1          high in any state but IDLE
//  o_Pkt_Done     out  1          1-cycle pulse: last byte of packet finished (after its TX_Done)
//  o_Abort        out  1          1-cycle pulse: packet dropped on gap timeout
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0 (ch0 highest priority first), counters 0.
//  States: IDLE, HDR, FETCH, LAUNCH, WAIT_DONE, GAP.
//  IDLE: any i_Req_Valid -> pick first valid ch at/after rr pointer (wrap), register o_Grant;
//   -> HDR if HEADER_EN else FETCH. Grant decision 1 cycle; no ready in IDLE.
//  HDR: load o_TX_Byte = {HEADER_TAG, 4'(chan id)}, -> LAUNCH, last_flag=0, hdr_flag=1.
//  FETCH: o_Req_Ready[g]=1 (only granted ch, only this state). On valid: capture byte + last into
//   o_TX_Byte/last_flag, -> LAUNCH. Gap counter counts FETCH cycles without valid; resets on accept.
//   Counter reaching GAP_TIMEOUT (nonzero) -> o_Abort pulse, rr pointer = g+1, -> IDLE.
//  LAUNCH: o_TX_DV=1 held until i_TX_Active sampled 1, then DV drops next cycle -> WAIT_DONE.
//   (Holding DV covers the TX's post-Done cleanup cycle, in which DV is ignored.)
//  WAIT_DONE: on i_TX_Done: header -> FETCH; data & !last -> FETCH; data & last -> o_Pkt_Done,
//   rr pointer = g+1 (mod NUM_CH), o_Grant=0, -> IDLE.
//  GAP: reserved encoding; any illegal state -> IDLE with outputs cleared.
//  Byte throughput: one byte per TX frame + 3 cycles scheduler overhead max.
//  Simultaneous: new valids on other channels never pre-empt an owned packet; valid on the
//   owner arriving in the same cycle the gap count hits the limit is accepted (accept wins).
//  Single-byte packet (last on first byte) legal. Ready never asserted while a byte is in TX.
//  i_TX_Done outside WAIT_DONE ignored (e.g., stale frame after scheduler reset).
//  Reset mid-packet: drop packet silently, no o_Abort, grant cleared next edge.
//  Widths: chan id $clog2(NUM_CH), zero-extended to 4 bits in header; gap counter
//   $clog2(GAP_TIMEOUT+1) bits, saturating.
// STRUCTURE
//  Shared include uart_defs.vh: state encodings, HEADER_TAG default, 8N1 byte width constant.
//  Sub-module rr_arbiter (NUM_CH): req vector + pointer -> one-hot grant + binary index, combinational.
//  Top: main FSM, gap counter, byte/last/hdr holding regs, pointer update.
// TESTING
//  Ch2 sends 3 bytes 11,22,33(last), HEADER_EN=1 -> TX sees A2,11,22,33; one o_Pkt_Done; grant=4'b0100.
//  Ch0 and ch3 both valid from reset -> ch0 packet fully first, then ch3; next contest of 0/3 -> ch3 wins after... ch0 (rr).
//  Ch1 stops after 1 byte, GAP_TIMEOUT=16 -> o_Abort 16 cycles into FETCH, grant cleared, ch2 then served.
//  TX model inserting cleanup cycle after Done -> no byte lost; exactly one DV-accept per byte.
//  Single-byte packet 55 on ch1, HEADER_EN=0 -> one TX frame 55, o_Pkt_Done, ready high 1 cycle only.
//  i_Rst pulsed during WAIT_DONE -> outputs 0 next edge; late i_TX_Done ignored; next packet clean.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART TX scheduler: FSM encoding,
// default header tag and width helpers.
package uart_tx_scheduler_pkg;

  localparam int BYTE_W = 8;
  localparam logic [3:0] DEF_HEADER_TAG = 4'hA;

  // ST_GAP is reserved; the FSM treats it like any other illegal encoding.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR       = 3'd1,
    ST_FETCH     = 3'd2,
    ST_LAUNCH    = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } state_t;

  function automatic int idx_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  function automatic int gap_cnt_width(input int timeout);
    if (timeout <= 0) return 1;
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after the
// pointer, wrapping at NUM_CH. Returns one-hot grant plus binary index.
module uart_tx_scheduler_rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IW     = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_Req,
  input  logic [IW-1:0]     i_Ptr,
  output logic [NUM_CH-1:0] o_Grant,
  output logic [IW-1:0]     o_Index,
  output logic              o_Any
);

  logic [IW:0] w_sum;
  logic [IW-1:0] w_ch;
  logic w_found;

  always_comb begin
    o_Grant = '0;
    o_Index = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_ch    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sum = {1'b0, i_Ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_CH)) w_sum = w_sum - (IW+1)'(NUM_CH);
      w_ch = w_sum[IW-1:0];
      if (!w_found && i_Req[w_ch]) begin
        w_found       = 1'b1;
        o_Grant[w_ch] = 1'b1;
        o_Index       = w_ch;
      end
    end
  end

  assign o_Any = w_found;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 8N1 UART transmitter between NUM_CH packet sources. The grant is
// held for a whole packet; an optional header byte tags each packet.
//
// Source handshake: a byte moves from channel k when i_Req_Valid[k] and
// o_Req_Ready[k] are both high at a rising edge; once valid is raised the
// source holds byte/last stable until that edge. Ready depends only on
// scheduler state, never on valid.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int         NUM_CH      = 4,
  parameter int         HEADER_EN   = 1,
  parameter logic [3:0] HEADER_TAG  = DEF_HEADER_TAG,
  parameter int         GAP_TIMEOUT = 1024
) (
  input  logic                     i_Clock,
  input  logic                     i_Rst,
  input  logic [NUM_CH-1:0]        i_Req_Valid,
  input  logic [BYTE_W*NUM_CH-1:0] i_Req_Byte,
  input  logic [NUM_CH-1:0]        i_Req_Last,
  output logic [NUM_CH-1:0]        o_Req_Ready,
  output logic                     o_TX_DV,
  output logic [BYTE_W-1:0]        o_TX_Byte,
  input  logic                     i_TX_Active,
  input  logic                     i_TX_Done,
  output logic [NUM_CH-1:0]        o_Grant,
  output logic                     o_Busy,
  output logic                     o_Pkt_Done,
  output logic                     o_Abort,
  output state_t                   o_Dbg_State
);

  localparam int IW      = idx_width(NUM_CH);
  localparam int GW      = gap_cnt_width(GAP_TIMEOUT);
  localparam int GAP_LIM = (GAP_TIMEOUT > 0) ? GAP_TIMEOUT - 1 : 0;
  localparam bit GAP_EN  = (GAP_TIMEOUT > 0);
  localparam bit HDR_ON  = (HEADER_EN != 0);

  state_t              r_state;
  state_t              w_next;
  logic [NUM_CH-1:0]   r_grant;
  logic [IW-1:0]       r_gidx;
  logic [IW-1:0]       r_ptr;
  logic [BYTE_W-1:0]   r_tx_byte;
  logic                r_last;
  logic                r_hdr;
  logic [GW-1:0]       r_gap_cnt;
  logic                r_pkt_done;
  logic                r_abort;

  logic [NUM_CH-1:0]   w_arb_grant;
  logic [IW-1:0]       w_arb_idx;
  logic                w_arb_any;
  logic                w_owner_valid;
  logic [BYTE_W-1:0]   w_owner_byte;
  logic                w_owner_last;
  logic [IW-1:0]       w_next_ptr;
  logic                w_accept;
  logic                w_abort;
  logic                w_pkt_end;
  logic                w_gap_hit;

  uart_tx_scheduler_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_arb (
    .i_Req   (i_Req_Valid),
    .i_Ptr   (r_ptr),
    .o_Grant (w_arb_grant),
    .o_Index (w_arb_idx),
    .o_Any   (w_arb_any)
  );

  assign w_owner_valid = |(i_Req_Valid & r_grant);
  assign w_owner_byte  = i_Req_Byte[{r_gidx, 3'b000} +: BYTE_W];
  assign w_owner_last  = i_Req_Last[r_gidx];
  assign w_next_ptr    = (r_gidx == IW'(NUM_CH - 1)) ? '0 : r_gidx + IW'(1);
  // Abort on the GAP_TIMEOUT-th consecutive FETCH cycle without owner valid.
  assign w_gap_hit     = GAP_EN && (r_gap_cnt == GW'(GAP_LIM));

  always_ff @(posedge i_Clock) begin
    if (i_Rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_abort   = 1'b0;
    w_pkt_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_any) w_next = HDR_ON ? ST_HDR : ST_FETCH;
      end
      ST_HDR: begin
        w_next = ST_LAUNCH;
      end
      ST_FETCH: begin
        if (w_owner_valid) begin
          w_accept = 1'b1;
          w_next   = ST_LAUNCH;
        end else if (w_gap_hit) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        if (i_TX_Active) w_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_TX_Done) begin
          if (!r_hdr && r_last) begin
            w_pkt_end = 1'b1;
            w_next    = ST_IDLE;
          end else begin
            w_next = ST_FETCH;
          end
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      r_grant    <= '0;
      r_gidx     <= '0;
      r_ptr      <= '0;
      r_tx_byte  <= '0;
      r_last     <= 1'b0;
      r_hdr      <= 1'b0;
      r_gap_cnt  <= '0;
      r_pkt_done <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_pkt_done <= w_pkt_end;
      r_abort    <= w_abort;
      case (r_state)
        ST_IDLE: begin
          r_gap_cnt <= '0;
          if (w_arb_any) begin
            r_grant <= w_arb_grant;
            r_gidx  <= w_arb_idx;
          end
        end
        ST_HDR: begin
          r_tx_byte <= {HEADER_TAG, 4'(r_gidx)};
          r_last    <= 1'b0;
          r_hdr     <= 1'b1;
        end
        ST_FETCH: begin
          if (w_accept) begin
            r_tx_byte <= w_owner_byte;
            r_last    <= w_owner_last;
            r_hdr     <= 1'b0;
            r_gap_cnt <= '0;
          end else if (w_abort) begin
            r_grant   <= '0;
            r_ptr     <= w_next_ptr;
            r_gap_cnt <= '0;
          end else if (r_gap_cnt != '1) begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        ST_LAUNCH: begin
        end
        ST_WAIT_DONE: begin
          if (w_pkt_end) begin
            r_grant <= '0;
            r_ptr   <= w_next_ptr;
          end
        end
        default: begin
          r_grant   <= '0;
          r_tx_byte <= '0;
          r_last    <= 1'b0;
          r_hdr     <= 1'b0;
          r_gap_cnt <= '0;
        end
      endcase
    end
  end

  assign o_Req_Ready = (r_state == ST_FETCH) ? r_grant : '0;
  assign o_TX_DV     = (r_state == ST_LAUNCH);
  assign o_TX_Byte   = r_tx_byte;
  assign o_Grant     = r_grant;
  assign o_Busy      = (r_state != ST_IDLE);
  assign o_Pkt_Done  = r_pkt_done;
  assign o_Abort     = r_abort;
  assign o_Dbg_State = r_state;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench: random packet traffic against a round-robin packet
// model, a UART TX model with a cleanup cycle, plus directed corner cases.
module tb_uart_tx_scheduler;
  import uart_tx_scheduler_pkg::*;

  localparam int         NUM_CH = 4;
  localparam int         GAP_T  = 16;
  localparam logic [3:0] TAG    = 4'hA;

  logic                  clk;
  logic                  i_Rst;
  logic [NUM_CH-1:0]     i_Req_Valid;
  logic [8*NUM_CH-1:0]   i_Req_Byte;
  logic [NUM_CH-1:0]     i_Req_Last;
  logic [NUM_CH-1:0]     o_Req_Ready;
  logic                  o_TX_DV;
  logic [7:0]            o_TX_Byte;
  logic                  i_TX_Active;
  logic                  i_TX_Done;
  logic [NUM_CH-1:0]     o_Grant;
  logic                  o_Busy;
  logic                  o_Pkt_Done;
  logic                  o_Abort;
  state_t                o_Dbg_State;

  uart_tx_scheduler #(
    .NUM_CH      (NUM_CH),
    .HEADER_EN   (1),
    .HEADER_TAG  (TAG),
    .GAP_TIMEOUT (GAP_T)
  ) dut (
    .i_Clock     (clk),
    .i_Rst       (i_Rst),
    .i_Req_Valid (i_Req_Valid),
    .i_Req_Byte  (i_Req_Byte),
    .i_Req_Last  (i_Req_Last),
    .o_Req_Ready (o_Req_Ready),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .i_TX_Active (i_TX_Active),
    .i_TX_Done   (i_TX_Done),
    .o_Grant     (o_Grant),
    .o_Busy      (o_Busy),
    .o_Pkt_Done  (o_Pkt_Done),
    .o_Abort     (o_Abort),
    .o_Dbg_State (o_Dbg_State)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [2:0] dly;
  } ent_t;

  ent_t              drv_q[NUM_CH][$];
  logic [8:0]        mdl_s[NUM_CH][$];
  logic [7:0]        exp_q[$];
  logic [NUM_CH-1:0] exp_g_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, mdl_ptr = 0;
  int exp_pkt, exp_abort, got_pkt, got_abort, tx_frames, ready_viol;
  int last_done_cyc = 0, abort_lat;
  int rdy_cycles[NUM_CH];
  logic [NUM_CH-1:0] grant_at_abort;
  int tx_st = 0, tx_cnt = 0;
  logic [NUM_CH-1:0] drv_valid = '0, ready_seen = '0;
  int dly_cnt[NUM_CH];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver / TX model / monitors (negedge) ----------------
  task automatic tx_accept();
    logic [7:0] eb;
    logic [NUM_CH-1:0] eg;
    tx_frames++;
    if (exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      eg = exp_g_q.pop_front();
      chk("tx_byte", 32'(o_TX_Byte), 32'(eb));
      chk("tx_grant", 32'(o_Grant), 32'(eg));
    end
  endtask

  task automatic bench_step();
    ent_t e;
    if (o_Pkt_Done) got_pkt++;
    if (o_Abort) begin
      got_abort++;
      abort_lat = cyc - last_done_cyc;
      grant_at_abort = o_Grant;
    end
    for (int ch = 0; ch < NUM_CH; ch++)
      if (o_Req_Ready[ch]) rdy_cycles[ch]++;
    if (((o_Req_Ready & ~o_Grant) != '0) || (tx_st == 1 && o_Req_Ready != '0))
      ready_viol++;
    // Transmitter: random DV pickup delay, random frame length, one cleanup cycle.
    case (tx_st)
      0: begin
        if (o_TX_DV && $urandom_range(0, 2) != 0) begin
          tx_accept();
          i_TX_Active = 1'b1;
          tx_cnt = $urandom_range(3, 8);
          tx_st = 1;
        end
      end
      1: begin
        if (tx_cnt > 0) tx_cnt--;
        else begin
          i_TX_Active = 1'b0;
          i_TX_Done = 1'b1;
          last_done_cyc = cyc;
          tx_st = 2;
        end
      end
      default: begin
        i_TX_Done = 1'b0;
        tx_st = 0;
      end
    endcase
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (drv_valid[ch] && ready_seen[ch]) begin
        e = drv_q[ch].pop_front();
        drv_valid[ch] = 1'b0;
        dly_cnt[ch] = 0;
      end
      if (!drv_valid[ch] && drv_q[ch].size() > 0) begin
        e = drv_q[ch][0];
        if (dly_cnt[ch] >= int'(e.dly)) begin
          drv_valid[ch] = 1'b1;
          i_Req_Byte[ch*8 +: 8] = e.data;
          i_Req_Last[ch] = e.last;
        end else begin
          dly_cnt[ch]++;
        end
      end
    end
    i_Req_Valid = drv_valid;
    ready_seen = o_Req_Ready;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      bench_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_byte(input int ch, input logic [7:0] d, input bit last, input int dly);
    ent_t e;
    e.data = d;
    e.last = last;
    e.dly  = 3'(dly);
    drv_q[ch].push_back(e);
    mdl_s[ch].push_back({last, d});
  endtask

  task automatic push_pkt_rand(input int ch);
    int n;
    n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++)
      push_byte(ch, 8'($urandom), (i == n - 1), (i == 0) ? 0 : $urandom_range(0, 4));
  endtask

  task automatic scn_clear();
    got_pkt = 0; got_abort = 0; exp_pkt = 0; exp_abort = 0;
    tx_frames = 0; ready_viol = 0; abort_lat = -1; grant_at_abort = '1;
    for (int ch = 0; ch < NUM_CH; ch++) rdy_cycles[ch] = 0;
    exp_q.delete();
    exp_g_q.delete();
  endtask

  // Packet-level model: serve whole packets in round-robin order starting at
  // the pointer; a stream that runs dry before its last byte is an abort.
  task automatic build_expected();
    int p, sel;
    bit done;
    logic [8:0] e;
    p = mdl_ptr;
    while (1) begin
      sel = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (p + k) % NUM_CH;
        if (sel < 0 && mdl_s[c].size() > 0) sel = c;
      end
      if (sel < 0) break;
      exp_q.push_back({TAG, 4'(sel)});
      exp_g_q.push_back(NUM_CH'(1) << sel);
      done = 0;
      while (mdl_s[sel].size() > 0 && !done) begin
        e = mdl_s[sel].pop_front();
        exp_q.push_back(e[7:0]);
        exp_g_q.push_back(NUM_CH'(1) << sel);
        if (e[8]) done = 1;
      end
      if (done) exp_pkt++;
      else exp_abort++;
      p = (sel + 1) % NUM_CH;
    end
    mdl_ptr = p;
  endtask

  function automatic bit drv_empty();
    for (int ch = 0; ch < NUM_CH; ch++)
      if (drv_q[ch].size() > 0) return 0;
    return 1;
  endfunction

  task automatic run_scn(input string tag, input int budget);
    int exp_frames;
    bit fin;
    build_expected();
    exp_frames = exp_q.size();
    fin = 0;
    for (int t = 0; t < budget && !fin; t++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !o_Busy && tx_st == 0 && drv_empty()) fin = 1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_finished"}, 32'(fin), 32'd1);
    chk({tag, "_frames"}, 32'(tx_frames), 32'(exp_frames));
    chk({tag, "_pkt_done"}, 32'(got_pkt), 32'(exp_pkt));
    chk({tag, "_abort"}, 32'(got_abort), 32'(exp_abort));
    chk({tag, "_ready_rules"}, 32'(ready_viol), 32'd0);
    chk({tag, "_grant_idle"}, 32'(o_Grant), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_grant"}, 32'(o_Grant), 32'd0);
    chk({tag, "_busy"}, 32'(o_Busy), 32'd0);
    chk({tag, "_tx_dv"}, 32'(o_TX_DV), 32'd0);
    chk({tag, "_ready"}, 32'(o_Req_Ready), 32'd0);
    chk({tag, "_pkt_done"}, 32'(o_Pkt_Done), 32'd0);
    chk({tag, "_abort"}, 32'(o_Abort), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit hit;
    i_Rst = 1'b1;
    i_Req_Valid = '0; i_Req_Byte = '0; i_Req_Last = '0;
    i_TX_Active = 1'b0; i_TX_Done = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) dly_cnt[ch] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    chk("reset_tx_byte", 32'(o_TX_Byte), 32'd0);
    i_Rst = 1'b0;
    @(posedge clk); #1;

    // ch0 and ch3 contend from reset: ch0 first, then alternate.
    scn_clear();
    push_byte(0, 8'h01, 0, 0); push_byte(0, 8'h02, 1, 1);
    push_byte(0, 8'h03, 1, 0);
    push_byte(3, 8'h31, 1, 0);
    push_byte(3, 8'h32, 0, 0); push_byte(3, 8'h33, 1, 2);
    run_scn("rr_0_3", 2000);

    // ch2 three-byte packet: A2,11,22,33.
    scn_clear();
    push_byte(2, 8'h11, 0, 0); push_byte(2, 8'h22, 0, 3); push_byte(2, 8'h33, 1, 1);
    run_scn("ch2_pkt", 1000);

    // ch1 stalls after one byte; ch2 waits behind it.
    scn_clear();
    push_byte(1, 8'h5A, 0, 0);
    push_byte(2, 8'hC1, 0, 0); push_byte(2, 8'hC2, 1, 0);
    run_scn("gap_abort", 1000);
    // FETCH starts the cycle after Done; GAP_T idle FETCH cycles, then the pulse.
    chk("gap_abort_latency", 32'(abort_lat), 32'(GAP_T + 1));
    chk("gap_abort_grant", 32'(grant_at_abort), 32'd0);

    // Single-byte packet: ready must be high for exactly one cycle.
    scn_clear();
    push_byte(1, 8'h55, 1, 0);
    run_scn("single_byte", 500);
    chk("single_byte_ready_cycles", 32'(rdy_cycles[1]), 32'd1);

    // Random traffic rounds.
    for (int r = 0; r < 8; r++) begin
      bit any;
      scn_clear();
      any = 0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if ($urandom_range(0, 1) == 1) begin
          any = 1;
          for (int p = 0; p < $urandom_range(1, 3); p++) push_pkt_rand(ch);
        end
      end
      if (!any) push_pkt_rand(r % NUM_CH);
      run_scn($sformatf("rand%0d", r), 4000);
    end

    // Reset while waiting for a TX frame to finish.
    scn_clear();
    push_byte(0, 8'hE1, 0, 0); push_byte(0, 8'hE2, 1, 0);
    build_expected();
    hit = 0;
    for (int t = 0; t < 300 && !hit; t++) begin
      @(posedge clk); #1;
      if (o_Dbg_State == ST_WAIT_DONE) hit = 1;
    end
    chk("rst_reached_wait_done", 32'(hit), 32'd1);
    i_Rst = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      drv_q[ch].delete();
      mdl_s[ch].delete();
    end
    drv_valid = '0;
    @(posedge clk); #1;
    check_outputs_zero("mid_rst");
    i_Rst = 1'b0;
    mdl_ptr = 0;
    exp_q.delete();
    exp_g_q.delete();
    got_pkt = 0; got_abort = 0;
    hit = 0;
    for (int t = 0; t < 100 && !hit; t++) begin
      @(posedge clk); #1;
      if (tx_st == 0) hit = 1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("stale_done_tx_idle", 32'(hit), 32'd1);
    chk("stale_done_busy", 32'(o_Busy), 32'd0);
    chk("stale_done_pkt_done", 32'(got_pkt), 32'd0);
    chk("stale_done_abort", 32'(got_abort), 32'd0);
    scn_clear();
    push_byte(3, 8'h77, 0, 0); push_byte(3, 8'h88, 1, 0);
    run_scn("after_rst", 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
